// File: rtl/debug_mon_pkg.sv
// Shared types and helpers for the debug monitor front end.
// Mode encoding matches the mode_sel pin; clog2_min1 keeps select widths >= 1.
package debug_mon_pkg;

  typedef enum logic [1:0] {
    MODE_LIVE   = 2'd0,
    MODE_PEAK   = 2'd1,
    MODE_RATE   = 2'd2,
    MODE_FREEZE = 2'd3
  } mon_mode_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces an active-low push button and emits a single
// pulse on each accepted press (debounced 1->0 edge); release is silent.
module key_debounce
  import debug_mon_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_raw,
  output logic press_pulse
);

  localparam int CW = clog2_min1(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic [CW-1:0] cnt_reg;
  logic          press_reg;

  // The count only advances while the synchronised input disagrees with the
  // accepted level, so any bounce back to the old level restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      cnt_reg   <= '0;
      press_reg <= 1'b0;
    end else begin
      sync1_reg <= key_n_raw;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        level_reg <= sync2_reg;
        cnt_reg   <= '0;
        press_reg <= ~sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign press_pulse = press_reg;

endmodule

// File: rtl/debug_monitor_mux.sv
// Refresh-window display/LED front end: per-channel last/peak/rate tracking,
// button-stepped channel select and pulse-stretched status flags.
module debug_monitor_mux
  import debug_mon_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int W            = 32,
  parameter int FLAGS        = 8,
  parameter int REFRESH_DIV  = 500_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NCH*W-1:0]             ch_data,
  input  logic [NCH-1:0]               ch_valid,
  input  logic [FLAGS-1:0]             flags_in,
  input  logic                         btn_next_n,
  input  logic [1:0]                   mode_sel,
  output logic [W-1:0]                 value_out,
  output logic [clog2_min1(NCH)-1:0]   value_ch,
  output logic [FLAGS-1:0]             flags_out,
  output logic                         refresh_tick
);

  localparam int SEL_W = clog2_min1(NCH);
  localparam int RCW   = clog2_min1(REFRESH_DIV);
  localparam logic [RCW-1:0]   REF_LAST = RCW'(REFRESH_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NCH - 1);

  logic [RCW-1:0]   ref_cnt_reg;
  logic             tick_reg;
  logic             at_end;
  logic [SEL_W-1:0] sel_reg;
  logic [W-1:0]     value_reg;
  logic [SEL_W-1:0] value_ch_reg;
  logic [FLAGS-1:0] sticky_reg;
  logic [FLAGS-1:0] flags_reg;
  logic             press;
  mon_mode_t        mode;

  logic [W-1:0] last_vec [NCH];
  logic [W-1:0] peak_vec [NCH];
  logic [W-1:0] rate_vec [NCH];

  assign at_end = (ref_cnt_reg == REF_LAST);
  assign mode   = mon_mode_t'(mode_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt_reg <= '0;
      tick_reg    <= 1'b0;
    end else begin
      ref_cnt_reg <= at_end ? '0 : ref_cnt_reg + 1'b1;
      tick_reg    <= at_end;
    end
  end

  // Events on the boundary cycle seed the next window instead of the one
  // being captured, so the capture reads the pre-update registers.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [W-1:0] last_reg;
      logic [W-1:0] peak_reg;
      logic [W-1:0] rate_reg;
      logic [W-1:0] sample;

      assign sample = ch_data[gi*W +: W];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          last_reg <= '0;
          peak_reg <= '0;
          rate_reg <= '0;
        end else begin
          if (ch_valid[gi]) begin
            last_reg <= sample;
          end
          if (at_end) begin
            peak_reg <= ch_valid[gi] ? sample : '0;
            rate_reg <= ch_valid[gi] ? W'(1) : '0;
          end else if (ch_valid[gi]) begin
            if (sample > peak_reg) begin
              peak_reg <= sample;
            end
            if (rate_reg != '1) begin
              rate_reg <= rate_reg + 1'b1;
            end
          end
        end
      end

      assign last_vec[gi] = last_reg;
      assign peak_vec[gi] = peak_reg;
      assign rate_vec[gi] = rate_reg;
    end
  endgenerate

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_key_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n_raw  (btn_next_n),
    .press_pulse(press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg <= '0;
    end else if (press) begin
      sel_reg <= (sel_reg == SEL_LAST) ? '0 : sel_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_reg    <= '0;
      value_ch_reg <= '0;
      sticky_reg   <= '0;
      flags_reg    <= '0;
    end else begin
      if (at_end) begin
        flags_reg  <= sticky_reg;
        sticky_reg <= flags_in;
        case (mode)
          MODE_LIVE: begin
            value_reg    <= last_vec[sel_reg];
            value_ch_reg <= sel_reg;
          end
          MODE_PEAK: begin
            value_reg    <= peak_vec[sel_reg];
            value_ch_reg <= sel_reg;
          end
          MODE_RATE: begin
            value_reg    <= rate_vec[sel_reg];
            value_ch_reg <= sel_reg;
          end
          default: begin
            value_reg    <= value_reg;
            value_ch_reg <= value_ch_reg;
          end
        endcase
      end else begin
        sticky_reg <= sticky_reg | flags_in;
      end
    end
  end

  assign value_out    = value_reg;
  assign value_ch     = value_ch_reg;
  assign flags_out    = flags_reg;
  assign refresh_tick = tick_reg;

endmodule

// File: tb/tb_debug_monitor_mux.sv
// Directed bench for debug_monitor_mux with a short refresh window and
// debounce time; every check is an immediate assertion on a hand-computed value.
module tb_debug_monitor_mux;

  localparam int NCH = 4;
  localparam int W = 16;
  localparam int FLAGS = 8;
  localparam int REFRESH_DIV = 10;
  localparam int DEBOUNCE_CYC = 4;

  logic             clk;
  logic             rst_n;
  logic [NCH*W-1:0] ch_data;
  logic [NCH-1:0]   ch_valid;
  logic [FLAGS-1:0] flags_in;
  logic             btn_next_n;
  logic [1:0]       mode_sel;
  logic [W-1:0]     value_out;
  logic [1:0]       value_ch;
  logic [FLAGS-1:0] flags_out;
  logic             refresh_tick;

  int checks;
  int fails;
  int ph;

  logic [1:0]  wrap_prev [4];
  logic [1:0]  wrap_ch   [4];
  logic [15:0] wrap_val  [4];

  debug_monitor_mux #(
    .NCH(NCH), .W(W), .FLAGS(FLAGS),
    .REFRESH_DIV(REFRESH_DIV), .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .ch_valid(ch_valid),
    .flags_in(flags_in), .btn_next_n(btn_next_n), .mode_sel(mode_sel),
    .value_out(value_out), .value_ch(value_ch), .flags_out(flags_out),
    .refresh_tick(refresh_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[%0t] check %s observed=%h expected=%h", $time, tag, obs, exp);
  endtask

  // ph mirrors the refresh counter value after each rising edge.
  task automatic go(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % REFRESH_DIV;
    end
  endtask

  task automatic to_phase(input int p);
    do go(1); while (ph != p);
  endtask

  task automatic pulse_ch(input int ch, input logic [15:0] d);
    ch_data[ch*W +: W] = d;
    ch_valid[ch] = 1'b1;
    go(1);
    ch_valid[ch] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    fails = 0;
    ph = 0;
    rst_n = 1'b0;
    ch_data = '0;
    ch_valid = '0;
    flags_in = '0;
    btn_next_n = 1'b1;
    mode_sel = 2'd0;
    #22;
    chk("rst_value", 32'(value_out), 32'h0);
    chk("rst_ch", 32'(value_ch), 32'h0);
    chk("rst_flags", 32'(flags_out), 32'h0);
    chk("rst_tick", 32'(refresh_tick), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ph = 0;

    // reset mid-window discards sticky flags
    go(3);
    flags_in = 8'h81;
    go(1);
    flags_in = 8'h00;
    to_phase(0);
    chk("pre_flags", 32'(flags_out), 32'h81);
    chk("pre_tick", 32'(refresh_tick), 32'h1);
    to_phase(5);
    flags_in = 8'h02;
    go(1);
    flags_in = 8'h00;
    rst_n = 1'b0;
    #2;
    chk("async_flags", 32'(flags_out), 32'h0);
    chk("async_value", 32'(value_out), 32'h0);
    chk("async_tick", 32'(refresh_tick), 32'h0);
    rst_n = 1'b1;
    ph = 0;
    go(9);
    chk("first_tick_early", 32'(refresh_tick), 32'h0);
    go(1);
    chk("first_tick", 32'(refresh_tick), 32'h1);
    chk("first_flags", 32'(flags_out), 32'h0);
    chk("first_value", 32'(value_out), 32'h0);

    // live mode on channel 0
    to_phase(2);
    pulse_ch(0, 16'h0012);
    to_phase(5);
    pulse_ch(0, 16'h0034);
    to_phase(0);
    chk("live_val", 32'(value_out), 32'h34);
    chk("live_ch", 32'(value_ch), 32'h0);
    to_phase(0);
    chk("live_hold", 32'(value_out), 32'h34);

    // bouncy button then held: exactly one step
    for (int k = 0; k < 2; k++) begin
      btn_next_n = 1'b0; go(2);
      btn_next_n = 1'b1; go(2);
    end
    btn_next_n = 1'b0;
    go(20);
    to_phase(0);
    chk("bounce_ch", 32'(value_ch), 32'h1);
    chk("bounce_val", 32'(value_out), 32'h0);
    btn_next_n = 1'b1;

    // peak mode on channel 1
    mode_sel = 2'd1;
    to_phase(2);
    pulse_ch(1, 16'd5);
    to_phase(4);
    pulse_ch(1, 16'd200);
    to_phase(6);
    pulse_ch(1, 16'd17);
    to_phase(0);
    chk("peak_val", 32'(value_out), 32'd200);
    chk("peak_ch", 32'(value_ch), 32'h1);
    to_phase(9);
    pulse_ch(1, 16'd9);
    chk("peak_empty", 32'(value_out), 32'd0);
    to_phase(0);
    chk("peak_on_t", 32'(value_out), 32'd9);

    // step to channel 2, rate mode
    btn_next_n = 1'b0;
    mode_sel = 2'd2;
    to_phase(8);
    chk("sel_not_yet", 32'(value_ch), 32'h1);
    to_phase(0);
    chk("rate_ch", 32'(value_ch), 32'h2);
    chk("rate_zero", 32'(value_out), 32'd0);
    btn_next_n = 1'b1;
    to_phase(3);
    for (int k = 0; k < 7; k++) pulse_ch(2, 16'h0100 + 16'(k));
    chk("rate_val", 32'(value_out), 32'd6);
    to_phase(0);
    chk("rate_carry", 32'(value_out), 32'd1);

    // freeze mode, flags keep updating
    mode_sel = 2'd3;
    to_phase(4);
    flags_in = 8'h08;
    go(1);
    flags_in = 8'h00;
    pulse_ch(2, 16'hBEEF);
    to_phase(0);
    chk("flag_set", 32'(flags_out), 32'h08);
    chk("freeze_val", 32'(value_out), 32'd1);
    chk("freeze_ch", 32'(value_ch), 32'h2);
    to_phase(5);
    chk("flag_hold", 32'(flags_out), 32'h08);
    to_phase(9);
    flags_in = 8'h08;
    go(1);
    flags_in = 8'h00;
    chk("flag_clear", 32'(flags_out), 32'h00);
    chk("freeze_val2", 32'(value_out), 32'd1);
    to_phase(0);
    chk("flag_on_t", 32'(flags_out), 32'h08);
    to_phase(0);
    chk("flag_gone", 32'(flags_out), 32'h00);

    // four clean presses wrap the select back around
    mode_sel = 2'd0;
    wrap_prev[0] = 2'd2; wrap_prev[1] = 2'd3; wrap_prev[2] = 2'd0; wrap_prev[3] = 2'd1;
    wrap_ch[0]   = 2'd3; wrap_ch[1]   = 2'd0; wrap_ch[2]   = 2'd1; wrap_ch[3]   = 2'd2;
    wrap_val[0]  = 16'h0000; wrap_val[1] = 16'h0034;
    wrap_val[2]  = 16'h0009; wrap_val[3] = 16'hBEEF;
    for (int k = 0; k < 4; k++) begin
      btn_next_n = 1'b0;
      to_phase(8);
      chk($sformatf("wrap_prev%0d", k), 32'(value_ch), 32'(wrap_prev[k]));
      to_phase(0);
      chk($sformatf("wrap_ch%0d", k), 32'(value_ch), 32'(wrap_ch[k]));
      chk($sformatf("wrap_val%0d", k), 32'(value_out), 32'(wrap_val[k]));
      btn_next_n = 1'b1;
      to_phase(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
